// File: rtl/div_pkg.sv
// Shared types and constants for the ratio-programmable clock divider.
// Optional feature macro: DIV_ODD_EN (odd ratios via a negedge half-cycle stretch).
package div_pkg;

    localparam int unsigned DIV_W_DEFAULT = 4;
    localparam int unsigned DIV_STOP      = 0;

    typedef enum logic [1:0] {
        IDLE,
        START,
        RUN,
        PEND
    } div_state_e;

endpackage

// File: rtl/div_core.sv
// Toggle generator: holds the active ratio, runs the period counter and drives clk_out.
// A load while idle preloads the counter so the first rising edge lands one cycle later;
// a load while active is only issued at a period boundary and swaps the ratio there.
// With DIV_ODD_EN defined, a negedge flop stretches the high phase by half a cycle for
// odd ratios; without it no negedge logic exists.
module div_core
    import div_pkg::*;
#(
    parameter int unsigned W = DIV_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] ratio_in,
    output logic         period_end,
    output logic         active,
    output logic         clk_out
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] cur_q, cur_d;
    logic         active_q, active_d;
    logic         hi_q, hi_d;

    // Next-state for counter, ratio and the posedge half of clk_out.
    always_comb begin
        cnt_d      = cnt_q;
        cur_d      = cur_q;
        active_d   = active_q;
        hi_d       = hi_q;
        period_end = active_q && (cnt_q == (cur_q - W'(1)));
        if (load && !active_q) begin
            // Preload to N-1 so the next edge wraps to 0 and raises clk_out.
            cur_d    = ratio_in;
            cnt_d    = ratio_in - W'(1);
            active_d = (ratio_in != W'(DIV_STOP));
            hi_d     = 1'b0;
        end else if (active_q) begin
            if (period_end) begin
                cnt_d = '0;
                hi_d  = 1'b1;
                if (load) begin
                    cur_d = ratio_in;
                    if (ratio_in == W'(DIV_STOP)) begin
                        active_d = 1'b0;
                        hi_d     = 1'b0;
                    end
                end
            end else begin
                cnt_d = cnt_q + W'(1);
                hi_d  = (cnt_d < (cur_q >> 1));
            end
        end
    end

    // Posedge state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            cur_q    <= '0;
            active_q <= 1'b0;
            hi_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            cur_q    <= cur_d;
            active_q <= active_d;
            hi_q     <= hi_d;
        end
    end

    assign active = active_q;

`ifdef DIV_ODD_EN
    logic neg_q, neg_d;

    // Half-cycle delayed copy of the high phase, only for odd ratios.
    always_comb begin
        neg_d = hi_q & cur_q[0];
    end

    // Negedge stretch flop; cleared on any negedge while rst is high.
    always_ff @(negedge clk) begin
        if (rst) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= neg_d;
        end
    end

    assign clk_out = hi_q | neg_q;
`else
    assign clk_out = hi_q;
`endif

endmodule

// File: rtl/div_ratio_ctrl.sv
// Ratio-request handshake and control FSM for the programmable clock divider.
// Requests are accepted when cfg_valid and cfg_ready are both high; changes while
// running are held in PEND and applied at the end of the current period.
// Optional feature macro: DIV_ODD_EN (odd ratios legal; otherwise rejected with err).
module div_ratio_ctrl
    import div_pkg::*;
#(
    parameter int unsigned W = DIV_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cfg_valid,
    input  logic [W-1:0] cfg_div,
    output logic         cfg_ready,
    output logic         clk_out,
    output logic         running,
    output logic         err
);

`ifdef DIV_ODD_EN
    localparam bit OddEn = 1'b1;
`else
    localparam bit OddEn = 1'b0;
`endif

    div_state_e   state_q, state_d;
    logic [W-1:0] ratio_q, ratio_d;
    logic         err_q, err_d;
    logic         load;
    logic         period_end;
    logic         req_stop;
    logic         req_legal;

    assign req_stop  = (cfg_div == W'(DIV_STOP));
    assign req_legal = (cfg_div >= W'(2)) && (OddEn || !cfg_div[0]);

    // Next-state, handshake and core strobe.
    always_comb begin
        state_d   = state_q;
        ratio_d   = ratio_q;
        err_d     = 1'b0;
        cfg_ready = 1'b0;
        load      = 1'b0;
        unique case (state_q)
            IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    if (req_stop) begin
                        // Already stopped: nothing to do.
                        state_d = IDLE;
                    end else if (req_legal) begin
                        ratio_d = cfg_div;
                        state_d = START;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            START: begin
                load    = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    if (req_stop || req_legal) begin
                        ratio_d = cfg_div;
                        state_d = PEND;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            PEND: begin
                if (period_end) begin
                    load    = 1'b1;
                    state_d = (ratio_q == W'(DIV_STOP)) ? IDLE : RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ratio_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ratio_q <= ratio_d;
            err_q   <= err_d;
        end
    end

    assign err = err_q;

    div_core #(
        .W(W)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .ratio_in  (ratio_q),
        .period_end(period_end),
        .active    (running),
        .clk_out   (clk_out)
    );

endmodule

// File: tb/tb_div_ratio_ctrl.sv
// Self-checking bench for div_ratio_ctrl: table of single-request vectors measured in
// half-cycle steps, plus hand-written ratio-change, stop, reject and reset sequences.
module tb_div_ratio_ctrl;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cfg_valid = 1'b0;
    logic [W-1:0] cfg_div = '0;
    logic         cfg_ready;
    logic         clk_out;
    logic         running;
    logic         err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] div;
        bit         want_err;
        bit         want_run;
        int         hi_halves;
        int         per_halves;
    } vec_t;

    vec_t vecs[9];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    div_ratio_ctrl #(
        .W(W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_valid(cfg_valid),
        .cfg_div  (cfg_div),
        .cfg_ready(cfg_ready),
        .clk_out  (clk_out),
        .running  (running),
        .err      (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int act, input int want);
        checks++;
        if (act != want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, want, $time);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        cfg_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_clk_out", int'(clk_out), 0);
        check("rst_running", int'(running), 0);
        check("rst_err", int'(err), 0);
        check("rst_ready", int'(cfg_ready), 1);
    endtask

    // Entered at a sample just after a rising edge; returns at the next rising edge.
    task automatic measure(output int hi, output int per);
        hi  = 0;
        per = 0;
        while (clk_out === 1'b1 && hi < 64) begin
            hi++;
            per++;
            #5;
        end
        while (clk_out !== 1'b1 && per < 128) begin
            per++;
            #5;
        end
    endtask

    task automatic run_vec(input vec_t v);
        vec_t e;
        int   hi;
        int   per;
        int   highs;
        do_reset();
        cfg_div   = v.div;
        cfg_valid = 1'b1;
        exp_q.push_back(v);
        tick();
        cfg_valid = 1'b0;
        e = exp_q.pop_front();
        check("err_pulse", int'(err), int'(e.want_err));
        tick();
        check("err_one_cycle", int'(err), 0);
        check("low_before_rise", int'(clk_out), 0);
        tick();
        check("rise_2nd_edge", int'(clk_out), int'(e.want_run));
        check("running", int'(running), int'(e.want_run));
        if (e.want_run) begin
            for (int p = 0; p < 2; p++) begin
                measure(hi, per);
                check("high_halves", hi, e.hi_halves);
                check("period_halves", per, e.per_halves);
            end
        end else begin
            highs = 0;
            for (int i = 0; i < 10; i++) begin
                tick();
                if (clk_out !== 1'b0) highs++;
            end
            check("stays_low", highs, 0);
            check("idle_ready", int'(cfg_ready), 1);
        end
    endtask

    // Reset, request n, return at the sample just after the first rising edge (k=0).
    task automatic start_at(input int n);
        do_reset();
        cfg_div   = W'(n);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic seq_switch();
        int want_clk;
        start_at(6);
        for (int k = 0; k <= 30; k++) begin
            if (k > 0) tick();
            want_clk = (k < 6) ? int'(k < 3) : int'(((k - 6) % 10) < 5);
            check("sw_clk", int'(clk_out), want_clk);
            check("sw_ready", int'(cfg_ready), (k >= 2 && k <= 5) ? 0 : 1);
            cfg_valid = (k == 1);
            cfg_div   = 4'd10;
        end
        cfg_valid = 1'b0;
    endtask

    task automatic seq_stop();
        start_at(4);
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) tick();
            check("stop_clk", int'(clk_out), (k < 4) ? int'((k % 4) < 2) : 0);
            check("stop_running", int'(running), int'(k < 4));
            check("stop_ready", int'(cfg_ready), (k >= 1 && k <= 3) ? 0 : 1);
            cfg_valid = (k == 0);
            cfg_div   = 4'd0;
        end
        cfg_valid = 1'b0;
    endtask

    task automatic seq_err_pend();
        int want_clk;
        start_at(6);
        for (int k = 0; k <= 30; k++) begin
            if (k > 0) tick();
            want_clk = (k < 6) ? int'(k < 3) : int'(((k - 6) % 8) < 4);
            check("ep_clk", int'(clk_out), want_clk);
            check("ep_err", int'(err), int'(k == 1));
            check("ep_ready", int'(cfg_ready), (k >= 2 && k <= 5) ? 0 : 1);
            cfg_valid = (k <= 4);
            cfg_div   = (k == 0) ? 4'd1 : (k == 1) ? 4'd8 : 4'd3;
        end
        cfg_valid = 1'b0;
    endtask

    task automatic seq_reset();
        int highs;
`ifdef DIV_ODD_EN
        start_at(7);
`else
        start_at(6);
`endif
        check("pre_rst_high", int'(clk_out), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("rst_mid_clk", int'(clk_out), 0);
        check("rst_mid_running", int'(running), 0);
        check("rst_mid_ready", int'(cfg_ready), 1);
        check("rst_mid_err", int'(err), 0);
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            #5;
            if (clk_out !== 1'b0) highs++;
        end
        check("rst_no_pending", highs, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4'd4,  1'b0, 1'b1, 4,  8};
        vecs[1] = '{4'd2,  1'b0, 1'b1, 2,  4};
        vecs[2] = '{4'd6,  1'b0, 1'b1, 6,  12};
        vecs[3] = '{4'd14, 1'b0, 1'b1, 14, 28};
        vecs[4] = '{4'd1,  1'b1, 1'b0, 0,  0};
        vecs[5] = '{4'd0,  1'b0, 1'b0, 0,  0};
`ifdef DIV_ODD_EN
        vecs[6] = '{4'd5,  1'b0, 1'b1, 5,  10};
        vecs[7] = '{4'd3,  1'b0, 1'b1, 3,  6};
        vecs[8] = '{4'd15, 1'b0, 1'b1, 15, 30};
`else
        vecs[6] = '{4'd5,  1'b1, 1'b0, 0,  0};
        vecs[7] = '{4'd3,  1'b1, 1'b0, 0,  0};
        vecs[8] = '{4'd15, 1'b1, 1'b0, 0,  0};
`endif
        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i]);
        end
        seq_switch();
        seq_stop();
        seq_err_pend();
        seq_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
